// File: rtl/calc_pkg.sv
// Shared types for the sequential calculator: operation codes and control FSM states.
package calc_pkg;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_MUL  = 2'b10,
    OP_RSVD = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_MUL_RUN = 2'b01,
    S_DONE    = 2'b10
  } state_e;

endpackage

// File: rtl/calc_mul_seq.sv
// Iterative shift-add multiplier: one partial product per cycle, WIDTH cycles per product.
// 'last' flags the final iteration; 'product' then already includes that iteration's partial.
module calc_mul_seq #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               last,
  output logic [2*WIDTH-1:0] product
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int PW    = 2 * WIDTH;

  logic [PW-1:0]    mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [PW-1:0]    acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic             run_q;

  assign product = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign last    = run_q && (cnt_q == CNT_W'(WIDTH - 1));

  // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      run_q    <= 1'b0;
    end else if (clear) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      run_q    <= 1'b0;
    end else if (start) begin
      mcand_q  <= {{WIDTH{1'b0}}, a};
      mplier_q <= b;
      acc_q    <= '0;
      cnt_q    <= '0;
      run_q    <= 1'b1;
    end else if (run_q) begin
      acc_q    <= product;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + 1'b1;
      if (last) run_q <= 1'b0;
    end
  end

endmodule

// File: rtl/calc_seq_alu.sv
// Two-operand calculator: operand registers, control FSM, ADD/SUB datapath and a sequential MUL.
// Define CALC_ACC_EN to enable chain mode (load_a_i in DONE copies the low result into A, adds ovf_o).
module calc_seq_alu
  import calc_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear_i,
  input  logic               load_a_i,
  input  logic               load_b_i,
  input  logic [WIDTH-1:0]   operand_i,
  input  logic [1:0]         op_i,
  input  logic               start_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               err_o,
  output logic               neg_o,
  output logic [WIDTH-1:0]   reg_a_o,
  output logic [WIDTH-1:0]   reg_b_o,
  output logic [2*WIDTH-1:0] result_o
`ifdef CALC_ACC_EN
  ,
  output logic               ovf_o
`endif
);

  localparam int PW = 2 * WIDTH;

  state_e           state_q, state_d;
  op_e              op;
  logic [WIDTH-1:0] a_q, b_q;
  logic [PW-1:0]    result_q;
  logic             err_q, neg_q;
  logic             start_go, mul_start, load_ok;
  logic             mul_last;
  logic [PW-1:0]    mul_product;
  logic [PW-1:0]    sum_w, diff_w;
  logic             a_lt_b;

  assign op        = op_e'(op_i);
  assign start_go  = !clear_i && start_i && (state_q == S_IDLE);
  assign mul_start = start_go && (op == OP_MUL);
  // A start in IDLE outranks any load presented in the same cycle.
  assign load_ok   = !clear_i && !start_i && (state_q == S_IDLE);

  assign a_lt_b = a_q < b_q;
  assign sum_w  = {{WIDTH{1'b0}}, a_q} + {{WIDTH{1'b0}}, b_q};
  assign diff_w = a_lt_b ? ({{WIDTH{1'b0}}, b_q} - {{WIDTH{1'b0}}, a_q})
                         : ({{WIDTH{1'b0}}, a_q} - {{WIDTH{1'b0}}, b_q});

  calc_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (clear_i),
    .start   (mul_start),
    .a       (a_q),
    .b       (b_q),
    .last    (mul_last),
    .product (mul_product)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: next state is defaulted first so no path through the case leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start_i) state_d = (op == OP_MUL) ? S_MUL_RUN : S_DONE;
      S_MUL_RUN: if (mul_last) state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
    if (clear_i) state_d = S_IDLE;
  end

  assign busy_o = (state_q == S_MUL_RUN);
  assign done_o = (state_q == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
      neg_q    <= 1'b0;
`ifdef CALC_ACC_EN
      ovf_o    <= 1'b0;
`endif
    end else if (clear_i) begin
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
      neg_q    <= 1'b0;
`ifdef CALC_ACC_EN
      ovf_o    <= 1'b0;
`endif
    end else begin
      if (load_ok) begin
        if (load_a_i) a_q <= operand_i;
        if (load_b_i) b_q <= operand_i;
      end
`ifdef CALC_ACC_EN
      if ((state_q == S_DONE) && load_a_i) begin
        a_q   <= result_q[WIDTH-1:0];
        ovf_o <= |result_q[PW-1:WIDTH];
      end
`endif
      if (start_go) begin
        err_q <= (op == OP_RSVD);
        neg_q <= 1'b0;
`ifdef CALC_ACC_EN
        ovf_o <= 1'b0;
`endif
        case (op)
          OP_ADD:  result_q <= sum_w;
          OP_SUB: begin
            result_q <= diff_w;
            neg_q    <= a_lt_b;
          end
          OP_RSVD: result_q <= '0;
          default: ;
        endcase
      end
      if ((state_q == S_MUL_RUN) && mul_last) result_q <= mul_product;
    end
  end

  assign reg_a_o  = a_q;
  assign reg_b_o  = b_q;
  assign result_o = result_q;
  assign err_o    = err_q;
  assign neg_o    = neg_q;

endmodule

// File: tb/tb_calc_seq_alu.sv
// Scoreboard bench for calc_seq_alu: the driver queues expected results, a monitor checks each done_o.
// Builds at WIDTH=4 by default and WIDTH=8 with CALC_ACC_EN.
module tb_calc_seq_alu;
  import calc_pkg::*;

`ifdef CALC_ACC_EN
  localparam int W = 8;
`else
  localparam int W = 4;
`endif
  localparam int PW = 2 * W;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clear_i = 1'b0, load_a_i = 1'b0, load_b_i = 1'b0, start_i = 1'b0;
  logic [W-1:0]  operand_i = '0;
  logic [1:0]    op_i = 2'b00;
  logic          busy_o, done_o, err_o, neg_o;
  logic [W-1:0]  reg_a_o, reg_b_o;
  logic [PW-1:0] result_o;
`ifdef CALC_ACC_EN
  logic          ovf_o;
`endif

  calc_seq_alu #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .clear_i(clear_i), .load_a_i(load_a_i), .load_b_i(load_b_i),
    .operand_i(operand_i), .op_i(op_i), .start_i(start_i), .busy_o(busy_o), .done_o(done_o),
    .err_o(err_o), .neg_o(neg_o), .reg_a_o(reg_a_o), .reg_b_o(reg_b_o), .result_o(result_o)
`ifdef CALC_ACC_EN
    , .ovf_o(ovf_o)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [PW-1:0] res;
    logic          neg;
    logic          err;
    int            due;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  logic [W-1:0]  ma = '0, mb = '0;
  logic [PW-1:0] mres = '0;
  logic          merr = 1'b0, mneg = 1'b0, movf = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [PW-1:0] ref_result(input logic [1:0] op, input logic [W-1:0] a,
                                               input logic [W-1:0] b);
    int unsigned ia = a, ib = b;
    case (op)
      2'b00:   return PW'(ia + ib);
      2'b01:   return PW'((ia >= ib) ? ia - ib : ib - ia);
      2'b10:   return PW'(ia * ib);
      default: return '0;
    endcase
  endfunction

  // Monitor: every done_o pulse must match the oldest queued expectation, on the expected cycle.
  always @(negedge clk) begin
    if (rst_n && done_o) begin
      if (sbq.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        mon_e = sbq.pop_front();
        check("done_result", result_o, mon_e.res);
        check("done_neg", neg_o, mon_e.neg);
        check("done_err", err_o, mon_e.err);
        check("done_cycle", cyc, mon_e.due);
        check("done_reg_a", reg_a_o, mon_e.a);
        check("done_reg_b", reg_b_o, mon_e.b);
      end
    end
  end

  task automatic zero_model();
    ma = '0; mb = '0; mres = '0; merr = 1'b0; mneg = 1'b0; movf = 1'b0;
  endtask

  // All tasks begin and end just after a falling edge with the inputs idle.
  task automatic load(input bit la, input bit lb, input logic [W-1:0] v);
    load_a_i = la; load_b_i = lb; operand_i = v;
    @(negedge clk);
    load_a_i = 1'b0; load_b_i = 1'b0;
    if (la) ma = v;
    if (lb) mb = v;
    check("load_reg_a", reg_a_o, ma);
    check("load_reg_b", reg_b_o, mb);
  endtask

  task automatic run_op(input logic [1:0] op, input bit acc, input bit with_load);
    exp_t e;
    e.res = ref_result(op, ma, mb);
    e.neg = (op == 2'b01) && (ma < mb);
    e.err = (op == 2'b11);
    e.due = cyc + ((op == 2'b10) ? W + 1 : 1);
    e.a   = ma;
    e.b   = mb;
    sbq.push_back(e);
    op_i = op; start_i = 1'b1;
    if (with_load) begin
      load_a_i = 1'b1; operand_i = ~ma;
    end
    @(negedge clk);
    start_i = 1'b0; load_a_i = 1'b0;
    if (op == 2'b10) begin
      for (int i = 0; i < W; i++) begin
        check("mul_busy", busy_o, 1);
        load_a_i = 1'b1; load_b_i = 1'b1; operand_i = W'($urandom);
        @(negedge clk);
      end
      load_a_i = 1'b0; load_b_i = 1'b0;
    end
    check("done_busy_low", busy_o, 0);
    check("done_pulse", done_o, 1);
    load_a_i = acc; operand_i = W'($urandom);
    mres = e.res; merr = e.err; mneg = e.neg; movf = 1'b0;
`ifdef CALC_ACC_EN
    if (acc) begin
      ma   = e.res[W-1:0];
      movf = |e.res[PW-1:W];
    end
`endif
    @(negedge clk);
    load_a_i = 1'b0;
    check("done_one_cycle", done_o, 0);
    check("hold_result", result_o, mres);
    check("hold_err", err_o, merr);
    check("hold_neg", neg_o, mneg);
    check("hold_reg_a", reg_a_o, ma);
    check("hold_reg_b", reg_b_o, mb);
`ifdef CALC_ACC_EN
    check("hold_ovf", ovf_o, movf);
`endif
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy_o, 0);
    check({tag, "_done"}, done_o, 0);
    check({tag, "_err"}, err_o, 0);
    check({tag, "_neg"}, neg_o, 0);
    check({tag, "_a"}, reg_a_o, 0);
    check({tag, "_b"}, reg_b_o, 0);
    check({tag, "_result"}, result_o, 0);
`ifdef CALC_ACC_EN
    check({tag, "_ovf"}, ovf_o, 0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] p;
    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases
    load(1, 1, '1);                run_op(2'b00, 0, 0);
    load(1, 0, W'(3)); load(0, 1, W'(9)); run_op(2'b01, 0, 0);
    load(1, 1, W'(9));             run_op(2'b01, 0, 0);
    load(1, 1, '1);                run_op(2'b10, 0, 0);
    load(1, 1, W'(5));             run_op(2'b11, 0, 0);
    run_op(2'b00, 0, 0);
    load(1, 0, W'(6)); load(0, 1, W'(2)); run_op(2'b00, 0, 1);

    // Chain mode: product with a zero low half and a non-zero high half
    p = W'(1 << (W / 2));
    load(1, 1, p);                 run_op(2'b10, 1, 0);

    // clear_i two cycles into a multiply aborts it without a done pulse
    load(1, 0, W'(7)); load(0, 1, W'(5));
    op_i = 2'b10; start_i = 1'b1;
    @(negedge clk); start_i = 1'b0;
    check("abort_busy_before", busy_o, 1);
    @(negedge clk); clear_i = 1'b1;
    @(negedge clk); clear_i = 1'b0;
    zero_model();
    check_all_zero("clear");
    repeat (W + 2) @(negedge clk);

    // Asynchronous reset mid-multiply
    load(1, 1, W'(3));
    op_i = 2'b10; start_i = 1'b1;
    @(negedge clk); start_i = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_reset");
    @(negedge clk); rst_n = 1'b1;
    zero_model();
    @(negedge clk);

    // Randomized operations against the reference model
    for (int n = 0; n < 40; n++) begin
      int sel = $urandom_range(0, 2);
      load(sel != 1, sel != 0, W'($urandom));
      if ($urandom_range(0, 3) == 0) load(1, 0, W'($urandom_range(0, 1) ? '1 : 0));
      run_op(2'($urandom_range(0, 3)), bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
    end

    repeat (3) @(negedge clk);
    check("queue_drained", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/calc_seq_alu.md
Name: calc_seq_alu

Overview:
Parametrised successor to the 4-bit switch-loaded adder. Holds two WIDTH-bit operand registers loaded from a shared operand bus and executes ADD, SUB (magnitude plus sign) or MUL (iterative shift-add) on a start strobe. Results are 2*WIDTH bits wide and are held for display. The block sits between the board input conditioning (debounced, single-cycle key pulses) and the seven-segment display drivers.

Parameters:
WIDTH, 4, operand width in bits (2..16)
CNT_W, $clog2(WIDTH+1), width of the multiply iteration counter (derived, localparam)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
clear_i  input  1  synchronous clear pulse
load_a_i  input  1  load operand_i into A (pulse)
load_b_i  input  1  load operand_i into B (pulse)
operand_i  input  WIDTH  operand bus (from switches)
op_i  input  2  operation: 00 ADD, 01 SUB, 10 MUL, 11 reserved
start_i  input  1  start-operation pulse
busy_o  output  1  multiply in progress
done_o  output  1  one-cycle result-valid pulse
err_o  output  1  last started op was reserved (sticky until next start/clear)
neg_o  output  1  SUB result negative (A<B)
reg_a_o  output  WIDTH  current A
reg_b_o  output  WIDTH  current B
result_o  output  2*WIDTH  result

Behaviour:
- Reset (async, rst_n=0): A, B, result_o, busy_o, done_o, err_o, neg_o all 0; FSM enters IDLE.
- FSM states: IDLE, MUL_RUN, DONE.
- Priority per cycle: clear_i > start_i > loads.
- clear_i in any state: A, B, result, flags and counter go to 0, FSM goes to IDLE. This also aborts a running MUL; done_o is not pulsed.
- Loads are accepted only in IDLE. load_a_i and load_b_i asserted together load both registers from operand_i. Loads in MUL_RUN or DONE are ignored.
- start_i is accepted only in IDLE. It latches op_i and clears err_o and neg_o. start_i in MUL_RUN or DONE is ignored.
- ADD: result = zero-extended A+B, registered on the start cycle. FSM goes IDLE->DONE. done_o is high in the cycle after start.
- SUB: result = |A-B| zero-extended; neg_o=1 iff A<B; A==B gives 0 with neg_o=0. Same timing as ADD.
- MUL: start cycle copies A and B into internal multiplicand/multiplier shadow registers, clears the accumulator, and enters MUL_RUN.
  - Each MUL_RUN cycle: if the multiplier LSB is 1, accumulator += shifted multiplicand; multiplicand shifts left, multiplier shifts right; counter increments.
  - After exactly WIDTH MUL_RUN cycles: FSM goes to DONE and result_o takes the accumulator.
  - busy_o is high in MUL_RUN only. done_o is high in cycle WIDTH+1 after start.
- Reserved op (11): result_o=0, err_o=1, DONE timing as ADD.
- DONE lasts exactly one cycle (done_o=1), then returns to IDLE.
- result_o holds its value until the next start completes or clear.
- A and B are unchanged by any operation.
- Width rules: all arithmetic runs at 2*WIDTH bits, so no overflow is possible.

Optional Feature:
Macro CALC_ACC_EN.
- Defined: in DONE, if load_a_i is high, A takes result_o[WIDTH-1:0] (accumulate / chain mode). Additional output ovf_o goes high when result_o[2*WIDTH-1:WIDTH] != 0 at that transfer. ovf_o is cleared by clear, reset or the next start.
- Undefined: loads in DONE are ignored as in the base behaviour; no ovf_o port.

Decomposition:
- Package calc_pkg: op_e enum (OP_ADD, OP_SUB, OP_MUL, OP_RSVD), state_e enum (S_IDLE, S_MUL_RUN, S_DONE).
- Sub-module calc_mul_seq: WIDTH-parametrised shift-add multiplier with start/done handshake. Owns the shadow registers, counter and accumulator.
- calc_seq_alu holds the operand registers, FSM and ADD/SUB datapath.

Test Plan:
- WIDTH=4: load A=0xF, B=0xF, ADD -> done_o in cycle 1, result_o=0x1E, neg_o=0.
- A=3, B=9, SUB -> result_o=0x06, neg_o=1. Then A=9, B=9, SUB -> result_o=0, neg_o=0.
- A=0xF, B=0xF, MUL -> busy_o high in cycles 1..4, done_o in cycle 5, result_o=0xE1. Load attempts during busy leave A and B unchanged.
- MUL started with A=7, B=5; clear_i in cycle 2 -> busy_o=0 next cycle, no done_o pulse, result_o=0, A=B=0. rst_n pulsed low mid-MUL -> all outputs 0 asynchronously.
- op=11 -> err_o=1, result_o=0. The next ADD clears err_o. start_i and load_a_i in the same IDLE cycle -> only start takes effect.
- WIDTH=8 (CALC_ACC_EN defined): A=0x10, B=0x10, MUL -> result_o=0x0100; load_a_i during DONE -> A=0x00, ovf_o=1.
